exec_result_fifo: RTL and testbench

//  Per-execution-unit result holding queue on the producer side of the writeback arbiter.

---
 rtl/exec_result_fifo.sv | 111 +++++++++++
 tb/tb_exec_result_fifo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/exec_result_fifo.sv
// exec_result_fifo: per-unit result queue feeding the writeback arbiter.
// Optional idle-queue same-cycle bypass: define RESULT_BYPASS_EN.
module exec_result_fifo #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [REG_W-1:0]  in_dest,
  output logic              is_req,
  input  logic              stall,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [REG_W-1:0]  out_dest,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [TAG_W-1:0]  mem_tag  [DEPTH];
  logic [REG_W-1:0]  mem_dest [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             head_vld;
  logic             push;
  logic             pop;
  logic             byp_take;

  assign head_vld = (count != '0);
  // Depends on occupancy only, so stall never reaches in_ready.
  assign in_ready = (count != CNT_W'(DEPTH));

`ifdef RESULT_BYPASS_EN
  logic byp;

  assign byp      = ~head_vld & in_valid & ~flush;
  // A bypassed result taken by the arbiter is never written.
  assign byp_take = byp & ~stall;
  assign is_req   = (head_vld & ~flush) | byp;

  // Head select: incoming result when bypassing, else stored head, else 0.
  always_comb begin
    out_data = '0;
    out_tag  = '0;
    out_dest = '0;
    if (byp) begin
      out_data = in_data;
      out_tag  = in_tag;
      out_dest = in_dest;
    end else if (head_vld) begin
      out_data = mem_data[rd_ptr];
      out_tag  = mem_tag[rd_ptr];
      out_dest = mem_dest[rd_ptr];
    end
  end
`else
  assign byp_take = 1'b0;
  assign is_req   = head_vld & ~flush;

  // Head select: stored head, gated to 0 while empty.
  always_comb begin
    out_data = '0;
    out_tag  = '0;
    out_dest = '0;
    if (head_vld) begin
      out_data = mem_data[rd_ptr];
      out_tag  = mem_tag[rd_ptr];
      out_dest = mem_dest[rd_ptr];
    end
  end
`endif

  assign push = in_valid & in_ready & ~flush & ~byp_take;
  assign pop  = head_vld & ~stall & ~flush;

  // Pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage write; contents need no reset since count gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_tag[wr_ptr]  <= in_tag;
      mem_dest[wr_ptr] <= in_dest;
    end
  end

endmodule

// File: tb/tb_exec_result_fifo.sv
// tb_exec_result_fifo: scoreboard bench for exec_result_fifo.
// Expected results are queued at drive time and compared at the head.
module tb_exec_result_fifo;

  localparam int DW = 32;
  localparam int TW = 6;
  localparam int RW = 5;
  localparam int DEPTH = 4;
  localparam int CW = 3;
`ifdef RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic [RW-1:0] dest;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [TW-1:0] in_tag = '0;
  logic [RW-1:0] in_dest = '0;
  logic          is_req;
  logic          stall = 1'b0;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic [RW-1:0] out_dest;
  logic [CW-1:0] count;

  ent_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  exec_result_fifo #(
    .DATA_W(DW), .TAG_W(TW), .REG_W(RW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .in_dest(in_dest),
    .is_req(is_req), .stall(stall),
    .out_data(out_data), .out_tag(out_tag), .out_dest(out_dest),
    .count(count)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic ent_t mk(input int t);
    ent_t e;
    e.tag  = TW'(t);
    e.data = 32'hA500_0000 ^ (32'(t) * 32'h0101_0101);
    e.dest = RW'(t) ^ 5'h1f;
    return e;
  endfunction

  // One cycle: drive, check before the edge, update model, cross edge.
  task automatic cyc(input bit v, input int t,
                     input bit st, input bit fl);
    ent_t e, h;
    bit   e_req, e_byp, take, acc;
    e = mk(t);
    in_valid = v;
    in_tag   = e.tag;
    in_data  = e.data;
    in_dest  = e.dest;
    stall    = st;
    flush    = fl;
    #3;
    e_byp = BYP && q.size() == 0 && v && !fl;
    e_req = (q.size() != 0 && !fl) || e_byp;
    check("is_req", 32'(is_req), 32'(e_req));
    check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    check("count", 32'(count), 32'(q.size()));
    if (q.size() != 0) h = q[0];
    else if (e_byp) h = e;
    else h = '0;
    check("out_tag", 32'(out_tag), 32'(h.tag));
    check("out_data", out_data, h.data);
    check("out_dest", 32'(out_dest), 32'(h.dest));
    if (fl) begin
      q.delete();
    end else begin
      acc  = v && q.size() != DEPTH;
      take = e_byp && !st;
      if (q.size() != 0 && !st) void'(q.pop_front());
      if (acc && !take) q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_req", 32'(is_req), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_tag", 32'(out_tag), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill with stall, then a 5th result that must be refused
    for (int i = 1; i <= 4; i++) cyc(1, i, 1, 0);
    cyc(1, 5, 1, 0);

    // Drain; first cycle also offers tag 5 while full
    cyc(1, 5, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Continuous push with alternating stall, then drain
    for (int i = 0; i < 8; i++) cyc(1, 10 + i, (i % 2) == 0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Flush with count=3 and a concurrent push of tag 9
    for (int i = 0; i < 3; i++) cyc(1, 20 + i, 1, 0);
    cyc(1, 9, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);

    // Single result into an idle queue, no stall
    cyc(1, 7, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Async reset mid-run with count=3
    for (int i = 0; i < 3; i++) cyc(1, 30 + i, 1, 0);
    check("pre_rst_count", 32'(count), 3);
    rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_req", 32'(is_req), 0);
    check("arst_ready", 32'(in_ready), 1);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 40, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
